// File: rtl/node_pkg.sv
// node_pkg: shared types and helpers for the mesh router cell.
//   P_L..P_W    : port indices (local, north, east, south, west)
//   flit_hdr_t  : header flit layout {len, dst_x, dst_y}
//   xy_route()  : dimension-order route, X resolved before Y
package node_pkg;

  localparam int P_L   = 0;
  localparam int P_N   = 1;
  localparam int P_E   = 2;
  localparam int P_S   = 3;
  localparam int P_W   = 4;
  localparam int HDR_W = 16;

  typedef struct packed {
    logic [7:0] len;
    logic [3:0] dst_x;
    logic [3:0] dst_y;
  } flit_hdr_t;

  function automatic logic [2:0] xy_route(input flit_hdr_t hdr,
                                          input logic [3:0] node_x,
                                          input logic [3:0] node_y);
    if (hdr.dst_x > node_x)      return 3'(P_E);
    else if (hdr.dst_x < node_x) return 3'(P_W);
    else if (hdr.dst_y > node_y) return 3'(P_N);
    else if (hdr.dst_y < node_y) return 3'(P_S);
    else                         return 3'(P_L);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with packet (wormhole) locking.
//   clk, rst : clock, async active-low reset
//   req      : per-input request
//   lock     : suppresses new grants (used for an absent output port)
//   rel      : granted input has just moved its last flit; drop the grant
//   grant    : registered one-hot grant, held until rel
// Search starts at ptr+1; on release ptr becomes the released input, so
// it gets lowest priority next round. No grant is issued in the release
// cycle itself.
module rr_arbiter #(
  parameter int NUM_REQ = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  input  logic               rel,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] pick;
  int                 idx;

  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = IW'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant <= '0;
      ptr   <= '0;
    end else if (|grant) begin
      if (rel) begin
        grant <= '0;
        ptr   <= gidx;
      end
    end else if (!lock) begin
      grant <= pick;
    end
  end

endmodule

// File: rtl/node_router.sv
// node_router: 5-port mesh router cell (L, N, E, S, W) with XY routing,
// per-input FIFO + packet tracker, per-output round-robin wormhole arbiter.
//   clk, rst     : clock, async active-low reset
//   in_valid     : upstream push per port
//   in_data      : input flits, port i at [i*DATA_W +: DATA_W]
//   in_full      : input FIFO full (held 0 on absent ports)
//   out_valid    : flit presented and consumed this cycle
//   out_data     : output flits (0 when not valid)
//   out_full     : downstream full per port
//   drop_pulse   : a header to an absent port was discarded this cycle
//   overflow_err : sticky, a push arrived while its FIFO was full
// PORT_MASK removes edge ports; packets routed to a removed port are
// drained one flit per cycle.
module node_router
  import node_pkg::*;
#(
  parameter int                   NODE_X     = 0,
  parameter int                   NODE_Y     = 0,
  parameter int                   NUM_PORTS  = 5,
  parameter logic [NUM_PORTS-1:0] PORT_MASK  = 5'b11111,
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   DATA_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_full,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  input  logic [NUM_PORTS-1:0]        out_full,
  output logic                        drop_pulse,
  output logic                        overflow_err
);

  localparam int         AW = $clog2(FIFO_DEPTH);
  localparam int         CW = AW + 1;
  localparam logic [3:0] NX = 4'(NODE_X);
  localparam logic [3:0] NY = 4'(NODE_Y);

  typedef enum logic {S_HEAD, S_BODY} trk_t;

  logic [NUM_PORTS-1:0][DATA_W-1:0]    head;
  logic [NUM_PORTS-1:0]                nempty, pop, last, drop_hdr, ovf;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;  // [output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;  // [output][input]

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    if (PORT_MASK[i]) begin : g_on
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0]     wp, rp;
      logic [CW-1:0]     cnt;
      trk_t              st;
      logic [7:0]        rem;
      logic              drop_q;
      flit_hdr_t         hdr;
      logic [2:0]        rt;
      logic              rt_ok, full, push, gpop;

      assign head[i]   = mem[rp];
      assign hdr       = flit_hdr_t'(mem[rp][HDR_W-1:0]);
      assign full      = (cnt == CW'(FIFO_DEPTH));
      assign push      = in_valid[i] & ~full;
      assign nempty[i] = (cnt != '0);
      assign in_full[i] = full;
      assign ovf[i]    = in_valid[i] & full;

      // Route is only meaningful while the head flit is a header (S_HEAD).
      assign rt          = xy_route(hdr, NX, NY);
      assign rt_ok       = PORT_MASK[rt];
      assign drop_hdr[i] = (st == S_HEAD) & nempty[i] & ~rt_ok;
      assign last[i]     = (st == S_HEAD) ? (hdr.len == 8'd0) : (rem == 8'd1);

      for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
        assign req[o][i] = (st == S_HEAD) & nempty[i] & rt_ok & (rt == 3'(o));
      end

      always_comb begin
        gpop = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) gpop = gpop | (gnt[o][i] & ~out_full[o]);
      end

      // Pop either by a granted transfer or by draining a dropped packet.
      assign pop[i] = nempty[i] & (gpop | drop_hdr[i] | ((st == S_BODY) & drop_q));

      always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_data[i*DATA_W +: DATA_W];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wp     <= '0;
          rp     <= '0;
          cnt    <= '0;
          st     <= S_HEAD;
          rem    <= '0;
          drop_q <= 1'b0;
        end else begin
          if (push)   wp <= wp + 1'b1;
          if (pop[i]) rp <= rp + 1'b1;
          cnt <= cnt + CW'(push) - CW'(pop[i]);
          if (pop[i]) begin
            if (st == S_HEAD) begin
              if (hdr.len != 8'd0) begin
                st     <= S_BODY;
                rem    <= hdr.len;
                drop_q <= ~rt_ok;
              end
            end else begin
              rem <= rem - 1'b1;
              if (rem == 8'd1) begin
                st     <= S_HEAD;
                drop_q <= 1'b0;
              end
            end
          end
        end
      end
    end else begin : g_off
      assign head[i]     = '0;
      assign nempty[i]   = 1'b0;
      assign pop[i]      = 1'b0;
      assign last[i]     = 1'b0;
      assign drop_hdr[i] = 1'b0;
      assign ovf[i]      = 1'b0;
      assign in_full[i]  = 1'b0;
      for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
        assign req[o][i] = 1'b0;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic              v, r;
    logic [DATA_W-1:0] d;

    always_comb begin
      v = 1'b0;
      r = 1'b0;
      d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[o][i] & nempty[i] & ~out_full[o]) begin
          v = 1'b1;
          r = last[i];
          d = head[i];
        end
      end
    end

    assign out_valid[o]               = v;
    assign out_data[o*DATA_W +: DATA_W] = d;

    rr_arbiter #(.NUM_REQ(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req[o]),
      .lock  (~PORT_MASK[o]),
      .rel   (r),
      .grant (gnt[o])
    );
  end

  assign drop_pulse = |drop_hdr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      overflow_err <= 1'b0;
    else if (|ovf) overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_node_router.sv
// tb_node_router: directed vectors against three router configurations:
//   u0 node (1,1) all ports, u1 node (0,0) ports L/N/E, u2 node (0,0) ports L/E.
module tb_node_router;

  typedef struct {
    int          d;
    logic [4:0]  iv;
    logic [79:0] idat;
    logic [4:0]  of;
    logic [4:0]  ev;
    logic [79:0] ed;
    logic [4:0]  ef;
    logic        edrp;
    logic        eovf;
  } vec_t;

  logic        clk, rst;
  logic [4:0]  iv   [3];
  logic [79:0] idat [3];
  logic [4:0]  ofl  [3];
  logic [4:0]  ifl  [3];
  logic [4:0]  ov   [3];
  logic [79:0] od   [3];
  logic        drp  [3];
  logic        oe   [3];

  int pass_cnt = 0;
  int total    = 0;

  node_router #(.NODE_X(1), .NODE_Y(1), .PORT_MASK(5'b11111)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_full(ifl[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_full(ofl[0]),
    .drop_pulse(drp[0]), .overflow_err(oe[0]));

  node_router #(.NODE_X(0), .NODE_Y(0), .PORT_MASK(5'b00111)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_full(ifl[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_full(ofl[1]),
    .drop_pulse(drp[1]), .overflow_err(oe[1]));

  node_router #(.NODE_X(0), .NODE_Y(0), .PORT_MASK(5'b00101)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(idat[2]), .in_full(ifl[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_full(ofl[2]),
    .drop_pulse(drp[2]), .overflow_err(oe[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] at(input int p, input logic [15:0] v);
    logic [79:0] r;
    r = '0;
    r[p*16 +: 16] = v;
    return r;
  endfunction

  function automatic vec_t mk(input int d, input logic [4:0] i_v, input logic [79:0] i_d,
                              input logic [4:0] o_f, input logic [4:0] e_v,
                              input logic [79:0] e_d, input logic [4:0] e_f,
                              input logic e_drp, input logic e_ovf);
    vec_t v;
    v.d = d; v.iv = i_v; v.idat = i_d; v.of = o_f;
    v.ev = e_v; v.ed = e_d; v.ef = e_f; v.edrp = e_drp; v.eovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic check_outs(input string tag, input int d, input logic [4:0] ev,
                            input logic [79:0] ed, input logic [4:0] ef,
                            input logic edrp, input logic eovf);
    chk({tag, " out_valid"},    80'(ov[d]),  80'(ev));
    chk({tag, " out_data"},     od[d],       ed);
    chk({tag, " in_full"},      80'(ifl[d]), 80'(ef));
    chk({tag, " drop_pulse"},   80'(drp[d]), 80'(edrp));
    chk({tag, " overflow_err"}, 80'(oe[d]),  80'(eovf));
  endtask

  // Inputs change at the falling edge; outputs are checked 1 ns later,
  // well before the next rising edge commits the cycle.
  task automatic step(input string tag, input int n, input vec_t v);
    @(negedge clk);
    iv[v.d]   = v.iv;
    idat[v.d] = v.idat;
    ofl[v.d]  = v.of;
    #1;
    check_outs($sformatf("%s c%0d", tag, n), v.d, v.ev, v.ed, v.ef, v.edrp, v.eovf);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0; idat[k] = '0; ofl[k] = '0;
    end
  endtask

  vec_t tv[$];
  vec_t sq[$];

  initial begin
    rst = 1'b0;
    idle_all();

    // single packet L->E, then W and S race for L
    tv.push_back(mk(0, 5'b00001, at(0,16'h0234), 0, 0,        0,               0, 0, 0));
    tv.push_back(mk(0, 5'b00001, at(0,16'hA001), 0, 0,        0,               0, 0, 0));
    tv.push_back(mk(0, 5'b00001, at(0,16'hA002), 0, 5'b00100, at(2,16'h0234),  0, 0, 0));
    tv.push_back(mk(0, 0,        0,              0, 5'b00100, at(2,16'hA001),  0, 0, 0));
    tv.push_back(mk(0, 0,        0,              0, 5'b00100, at(2,16'hA002),  0, 0, 0));
    tv.push_back(mk(0, 0,        0,              0, 0,        0,               0, 0, 0));
    tv.push_back(mk(0, 5'b11000, at(4,16'h0311)|at(3,16'h0311), 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 5'b11000, at(4,16'h4441)|at(3,16'h3331), 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 5'b11000, at(4,16'h4442)|at(3,16'h3332), 0, 5'b00001, at(0,16'h0311), 0, 0, 0));
    tv.push_back(mk(0, 5'b11000, at(4,16'h4443)|at(3,16'h3333), 0, 5'b00001, at(0,16'h3331), 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h3332), 5'b10000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h3333), 5'b10000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,        0,              5'b10000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h0311), 5'b10000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h4441), 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h4442), 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 5'b00001, at(0,16'h4443), 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,        0,              0, 0, 0));

    #2;
    for (int k = 0; k < 3; k++) check_outs($sformatf("reset u%0d", k), k, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[k]) step("tbl", k, tv[k]);

    // E stalled 5 cycles mid-packet; N's header must wait for the release
    sq.delete();
    sq.push_back(mk(0, 5'b00001, at(0,16'h0334), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hC001), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(0, 5'b00011, at(0,16'hC002)|at(1,16'h0034), 0, 5'b00100, at(2,16'h0334), 0, 0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hC003), 0, 5'b00100, at(2,16'hC001), 0, 0, 0));
    for (int k = 0; k < 5; k++) sq.push_back(mk(0, 0, 0, 5'b00100, 0, 0, 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 5'b00100, at(2,16'hC002), 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 5'b00100, at(2,16'hC003), 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 5'b00100, at(2,16'h0034), 0, 0, 0));
    sq.push_back(mk(0, 0, 0, 0, 0,        0,              0, 0, 0));
    foreach (sq[k]) step("stall", k, sq[k]);

    // masked routing: u1 forwards to N, u2 drops header + body
    sq.delete();
    sq.push_back(mk(1, 5'b00100, at(2,16'h010F), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 5'b00100, at(2,16'hD001), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 5'b00010, at(1,16'h010F), 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 5'b00010, at(1,16'hD001), 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(2, 5'b10100, at(2,16'h010F)|at(4,16'hFFFF), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(2, 5'b00100, at(2,16'hD001), 0, 0, 0, 0, 1, 0));
    sq.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(2, 5'b00100, at(2,16'h0010), 0, 0, 0, 0, 0, 0));
    sq.push_back(mk(2, 0, 0, 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(2, 0, 0, 0, 5'b00100, at(2,16'h0010), 0, 0, 0));
    sq.push_back(mk(2, 0, 0, 0, 0,        0,              0, 0, 0));
    foreach (sq[k]) step("mask", k, sq[k]);

    // overflow: E held full while L pushes 5 flits into a 4-deep FIFO
    sq.delete();
    sq.push_back(mk(0, 5'b00001, at(0,16'h0534), 5'b00100, 0, 0, 0,        0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hB001), 5'b00100, 0, 0, 0,        0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hB002), 5'b00100, 0, 0, 0,        0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hB003), 5'b00100, 0, 0, 0,        0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hB004), 5'b00100, 0, 0, 5'b00001, 0, 0));
    sq.push_back(mk(0, 0, 0, 5'b00100, 0,        0,              5'b00001, 0, 1));
    sq.push_back(mk(0, 0, 0, 0,        5'b00100, at(2,16'h0534), 5'b00001, 0, 1));
    sq.push_back(mk(0, 0, 0, 0,        5'b00100, at(2,16'hB001), 0,        0, 1));
    sq.push_back(mk(0, 0, 0, 0,        5'b00100, at(2,16'hB002), 0,        0, 1));
    sq.push_back(mk(0, 0, 0, 0,        5'b00100, at(2,16'hB003), 0,        0, 1));
    sq.push_back(mk(0, 0, 0, 0,        0,        0,              0,        0, 1));
    foreach (sq[k]) step("ovf", k, sq[k]);

    // async reset clears sticky error and the stranded packet
    idle_all();
    #2 rst = 1'b0;
    #1 check_outs("ovf_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // reset asserted while the 2nd body flit is on E
    sq.delete();
    sq.push_back(mk(0, 5'b00001, at(0,16'h0334), 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hE001), 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hE002), 0, 5'b00100, at(2,16'h0334), 0, 0, 0));
    sq.push_back(mk(0, 5'b00001, at(0,16'hE003), 0, 5'b00100, at(2,16'hE001), 0, 0, 0));
    sq.push_back(mk(0, 0,        0,              0, 5'b00100, at(2,16'hE002), 0, 0, 0));
    foreach (sq[k]) step("rst_mid", k, sq[k]);
    #1 rst = 1'b0;
    #1 check_outs("rst_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // fresh self-addressed header; leftover E003 must not surface
    sq.delete();
    sq.push_back(mk(0, 5'b00001, at(0,16'h0011), 0, 0,        0,              0, 0, 0));
    sq.push_back(mk(0, 0,        0,              0, 0,        0,              0, 0, 0));
    sq.push_back(mk(0, 0,        0,              0, 5'b00001, at(0,16'h0011), 0, 0, 0));
    sq.push_back(mk(0, 0,        0,              0, 0,        0,              0, 0, 0));
    foreach (sq[k]) step("fresh", k, sq[k]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/node_router.md
Name: node_router

Overview:
- Parametrised successor to the fixed 3-port mesh node.
- One router cell with up to five ports (local, N, E, S, W). A PORT_MASK parameter removes absent edge ports, so the same block covers corner, edge and interior nodes.
- Each input has a FIFO and a packet-length tracker, and routes packets by dimension-order (XY) on the header address.
- Per-output round-robin arbitration with wormhole locking: a granted input holds its output until the packet's last flit leaves.

Parameters:
- NODE_X, 0, X coordinate of this node (4 bits used).
- NODE_Y, 0, Y coordinate of this node (4 bits used).
- NUM_PORTS, 5, fixed port count; index 0=L, 1=N, 2=E, 3=S, 4=W.
- PORT_MASK, 5'b11111, bit i=1 means port i exists.
- FIFO_DEPTH, 4, entries per input FIFO; power of 2, minimum 2.
- DATA_W, 16, flit width; header layout is [15:8] length, [7:0] address.

Ports:
- clk  input  1  single clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  NUM_PORTS  upstream pushes a flit on port i
- in_data  input  NUM_PORTS*DATA_W  input flits, port i at [i*DATA_W +: DATA_W]
- in_full  output  NUM_PORTS  input FIFO i full; upstream must not push
- out_valid  output  NUM_PORTS  flit presented and consumed on output i this cycle
- out_data  output  NUM_PORTS*DATA_W  output flits
- out_full  input  NUM_PORTS  downstream buffer i full
- drop_pulse  output  1  one-cycle pulse when a header is dropped
- overflow_err  output  1  sticky flag: push while full

Behaviour:
- Reset (rst=0, async), outputs and state:
  - all FIFOs empty, all flit counters 0, all grants released, round-robin pointers set to port 0;
  - in_full=0, out_valid=0, out_data=0, drop_pulse=0, overflow_err=0;
  - reset mid-packet discards all buffered flits; no partial-packet recovery.
- Packet format:
  - a header flit has length L in [15:8] and is followed by exactly L body flits (L may be 0);
  - address [7:4]=dest X, [3:0]=dest Y.
- Per-input tracker: a state of IDLE/HEAD or BODY plus an 8-bit remaining-flit counter.
  - In HEAD, the FIFO head is a header: compute route and request that output.
  - Header popped with L>0 -> BODY, counter=L.
  - Each body pop decrements the counter; 0 -> HEAD.
- Route (XY):
  - dx>NODE_X -> E; dx<NODE_X -> W;
  - else dy>NODE_Y -> N; dy<NODE_Y -> S;
  - else -> L. A local-to-local packet (self-addressed) is legal.
- Masked target:
  - if the routed port's PORT_MASK bit is 0, the header and its L body flits are popped and discarded one per cycle;
  - drop_pulse fires once on the header.
- Arbitration, per output:
  - round-robin over inputs requesting it in HEAD state, starting at pointer+1;
  - grant is locked until the granted input pops its last flit (header with L=0, or counter reaching 0);
  - on release the pointer is set to the released input, and a new grant may be issued in the next cycle.
- Transfer:
  - out_valid[o] = grant valid & granted FIFO non-empty & !out_full[o];
  - the same cycle pops the FIFO; out_data[o] = FIFO head (combinational);
  - out_data is 0 when out_valid is 0.
- Latency:
  - a flit pushed in cycle t can appear on out_valid in cycle t+2 (t+1 to reach the FIFO head, t+1 arbitration registered, t+2 out);
  - body flits stream at one per cycle.
- FIFO:
  - in_full = (count==FIFO_DEPTH);
  - simultaneous push and pop when non-full keeps count unchanged;
  - push while full: flit ignored, overflow_err set until reset;
  - inputs on masked ports are ignored and in_full held at 0.
- Backpressure mid-packet: out_full stalls the stream and the grant stays held; no other input may interleave.

Decomposition:
- Package node_pkg:
  - port index constants (P_L, P_N, P_E, P_S, P_W);
  - flit_hdr_t struct {len[7:0], dst_x[3:0], dst_y[3:0]};
  - function xy_route(hdr, node_x, node_y) returning the port index.
- Sub-module rr_arbiter (NUM_REQ parameter; req, lock, release in; grant one-hot out), instantiated once per output.
- FIFO and tracker are generated inline per port.

Test Plan:
- Node (1,1), header 0x0234 from L (dest x=3, y=4, L=2) + 2 body flits -> three consecutive out_valid on E, data unchanged, first at t+2.
- W and S inputs both send headers to L with L=3 in the same cycle -> W (index 4) or S is granted by pointer order; all 4 flits of the winner leave uninterrupted, then all 4 of the other.
- Node (0,0), PORT_MASK=5'b00111, header to x=0, y=0xF with L=1 arriving on E -> routes N; with N masked instead -> 2 flits discarded and drop_pulse pulses once.
- out_full[E] held high 5 cycles mid-packet -> no E out_valid during the stall, remaining body resumes next cycle, and no other input gains E.
- FIFO_DEPTH=4, 5 pushes with downstream full -> in_full=1 after the 4th push, 5th push sets overflow_err=1.
- rst low during the 2nd body flit -> all outputs 0 asynchronously; after release, a fresh header routes correctly with no leftover flits.
